sc_lanescroll_ctrl: RTL

SC_LANESCROLL_CTRL -- requirements
Module: sc_lanescroll_ctrl

---
 rtl/sc_lanescroll_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/sc_lanescroll_ctrl.sv
// ---------------------------------------------------------------------------
// sc_lanescroll_ctrl
//   Sequencer for NUM_LANES background-type lane shift registers.  A Moore FSM
//   walks IDLE -> CLEAR -> LOAD -> RUN.  In RUN a base-tick prescaler feeds a
//   per-lane down-counter.  When a lane's counter expires, that lane is marked
//   pending.  At most one pending lane is granted a shift per clock, and the
//   lowest index wins.  An 8-bit Fibonacci LFSR supplies a random nibble that
//   stays stable for the whole shift clock.  The LFSR steps on the clock edge
//   that ends each shift.
//
// Ports
//   SC_LaneScrollCtrl_CLOCK_50              clock, rising edge
//   SC_LaneScrollCtrl_RESET_InLow           async reset, active low
//   SC_LaneScrollCtrl_start_InLow           start/restart request, active low
//   SC_LaneScrollCtrl_pause_In              freeze scrolling while high
//   SC_LaneScrollCtrl_level_InBUS   [1:0]   speed level 0..3
//   SC_LaneScrollCtrl_period_InBUS  [PW]    clocks per base tick (0 acts as 1)
//   SC_LaneScrollCtrl_clear_OutLow  [N]     lane clear, low in CLEAR
//   SC_LaneScrollCtrl_load_OutLow   [N]     lane load, low in LOAD
//   SC_LaneScrollCtrl_shiftselection_OutBUS [2N] lane i = [2i+1:2i], 10 shift
//   SC_LaneScrollCtrl_random_OutBUS [3:0]   LFSR[3:0]
//   SC_LaneScrollCtrl_state_OutBUS  [1:0]   IDLE=00 CLEAR=01 LOAD=10 RUN=11
// ---------------------------------------------------------------------------

// Per-lane divider: a 5-bit down-counter of base ticks plus a pending flag.
module sc_lanescroll_lane #(
  parameter int IDX = 0
) (
  input  logic       SC_Lane_CLOCK_50,
  input  logic       SC_Lane_RESET_InLow,
  input  logic       flush,
  input  logic       reload,
  input  logic       tick,
  input  logic       grant,
  input  logic [1:0] level,
  output logic       pending
);
  logic [7:0] divFull;
  logic [4:0] reloadVal;
  logic [4:0] cnt;
  logic       due;

  // The division ratio is (IDX+1)*(4-level).  Level is only looked at here,
  // so a level change takes effect at the next reload.  A count already in
  // progress is never cut short.
  always_comb begin
    divFull   = 8'(IDX + 1) * (8'd4 - {6'd0, level});
    reloadVal = 5'(divFull - 8'd1);
  end

  assign due = tick && (cnt == 5'd0);

  always_ff @(posedge SC_Lane_CLOCK_50 or negedge SC_Lane_RESET_InLow) begin
    if (!SC_Lane_RESET_InLow) begin
      cnt     <= 5'd0;
      pending <= 1'b0;
    end else if (flush) begin
      cnt     <= 5'd0;
      pending <= 1'b0;
    end else if (reload) begin
      cnt     <= reloadVal;
      pending <= 1'b0;
    end else begin
      if (tick) cnt <= (cnt == 5'd0) ? reloadVal : cnt - 5'd1;
      // If the lane becomes due again, it stays pending.  This also holds when
      // it is being granted on the same clock, so no shift is lost.
      pending <= (pending && !grant) || due;
    end
  end
endmodule

module sc_lanescroll_ctrl #(
  parameter int         NUM_LANES = 4,
  parameter int         PERIODW   = 24,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                   SC_LaneScrollCtrl_CLOCK_50,
  input  logic                   SC_LaneScrollCtrl_RESET_InLow,
  input  logic                   SC_LaneScrollCtrl_start_InLow,
  input  logic                   SC_LaneScrollCtrl_pause_In,
  input  logic [1:0]             SC_LaneScrollCtrl_level_InBUS,
  input  logic [PERIODW-1:0]     SC_LaneScrollCtrl_period_InBUS,
  output logic [NUM_LANES-1:0]   SC_LaneScrollCtrl_clear_OutLow,
  output logic [NUM_LANES-1:0]   SC_LaneScrollCtrl_load_OutLow,
  output logic [2*NUM_LANES-1:0] SC_LaneScrollCtrl_shiftselection_OutBUS,
  output logic [3:0]             SC_LaneScrollCtrl_random_OutBUS,
  output logic [1:0]             SC_LaneScrollCtrl_state_OutBUS
);
  typedef enum logic [1:0] {IDLE = 2'b00, CLEAR = 2'b01, LOAD = 2'b10, RUN = 2'b11} state_t;

  state_t               state, stateNext;
  logic                 runEn;
  logic                 baseTick;
  logic [PERIODW-1:0]   presc;
  logic [PERIODW-1:0]   periodEff;
  logic [NUM_LANES-1:0] pending;
  logic [NUM_LANES-1:0] grant;
  logic [7:0]           lfsr;

  // ---- FSM: state register ----
  always_ff @(posedge SC_LaneScrollCtrl_CLOCK_50 or negedge SC_LaneScrollCtrl_RESET_InLow) begin
    if (!SC_LaneScrollCtrl_RESET_InLow) state <= IDLE;
    else                                state <= stateNext;
  end

  // ---- FSM: next state ----
  // A start request wins from any state.  In IDLE it starts the sequence;
  // anywhere else it restarts the sequence.
  always_comb begin
    stateNext = state;
    if (!SC_LaneScrollCtrl_start_InLow) begin
      stateNext = CLEAR;
    end else begin
      case (state)
        IDLE:    stateNext = IDLE;
        CLEAR:   stateNext = LOAD;
        LOAD:    stateNext = RUN;
        RUN:     stateNext = RUN;
        default: stateNext = IDLE;
      endcase
    end
  end

  // ---- FSM: Moore outputs ----
  always_comb begin
    SC_LaneScrollCtrl_clear_OutLow = (state == CLEAR) ? '0 : '1;
    SC_LaneScrollCtrl_load_OutLow  = (state == LOAD)  ? '0 : '1;
    SC_LaneScrollCtrl_state_OutBUS = state;
  end

  assign runEn = (state == RUN) && !SC_LaneScrollCtrl_pause_In;

  // ---- base-tick prescaler ----
  // The test is >= rather than ==.  If the period input shrinks below the
  // current count, the prescaler wraps at once instead of running to 2^PERIODW.
  assign periodEff = (SC_LaneScrollCtrl_period_InBUS == '0) ? PERIODW'(1)
                                                           : SC_LaneScrollCtrl_period_InBUS;
  assign baseTick  = runEn && (presc >= periodEff - PERIODW'(1));

  always_ff @(posedge SC_LaneScrollCtrl_CLOCK_50 or negedge SC_LaneScrollCtrl_RESET_InLow) begin
    if (!SC_LaneScrollCtrl_RESET_InLow) presc <= '0;
    else if (state != RUN)              presc <= '0;
    else if (runEn)                     presc <= baseTick ? '0 : presc + PERIODW'(1);
  end

  // ---- lanes ----
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : gLane
      sc_lanescroll_lane #(.IDX(gi)) uLane (
        .SC_Lane_CLOCK_50   (SC_LaneScrollCtrl_CLOCK_50),
        .SC_Lane_RESET_InLow(SC_LaneScrollCtrl_RESET_InLow),
        .flush              (state == CLEAR),
        .reload             (state == LOAD),
        .tick               (baseTick),
        .grant              (grant[gi]),
        .level              (SC_LaneScrollCtrl_level_InBUS),
        .pending            (pending[gi])
      );
    end
  endgenerate

  // The expression p & -p keeps only the lowest set bit.  That bit is the
  // single lane granted a shift this clock.
  assign grant = runEn ? (pending & (~pending + NUM_LANES'(1))) : '0;

  always_comb begin
    SC_LaneScrollCtrl_shiftselection_OutBUS = '0;
    for (int i = 0; i < NUM_LANES; i++)
      SC_LaneScrollCtrl_shiftselection_OutBUS[2*i +: 2] = grant[i] ? 2'b10 : 2'b00;
  end

  // ---- LFSR: taps 7,5,4,3; steps at the edge that ends a granted shift ----
  always_ff @(posedge SC_LaneScrollCtrl_CLOCK_50 or negedge SC_LaneScrollCtrl_RESET_InLow) begin
    if (!SC_LaneScrollCtrl_RESET_InLow) lfsr <= LFSR_SEED;
    else if (|grant)                    lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign SC_LaneScrollCtrl_random_OutBUS = lfsr[3:0];
endmodule
